// File: rtl/mux_nto1_seq.sv
// Registered N-to-1 channel multiplexer with manual select and timed auto-scan.
// Optional per-channel enable mask is compiled in with MUXSEQ_MASK_EN.
module mux_nto1_seq #(
  parameter  int N     = 8,
  parameter  int W     = 1,
  parameter  int DWELL = 4,
  localparam int SW    = $clog2(N)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N*W-1:0] in_i,
  input  logic [SW-1:0]  sel_i,
  input  logic           en_i,
  input  logic           mode_i,
`ifdef MUXSEQ_MASK_EN
  input  logic [N-1:0]   ch_mask_i,
`endif
  output logic [W-1:0]   out_o,
  output logic [SW-1:0]  out_sel_o,
  output logic           out_valid_o,
  output logic           sel_err_o,
  output logic           scan_wrap_o
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  out_q, out_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          wrap_q, wrap_d;
  logic [SW-1:0] cur_sel_q, cur_sel_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic          wrap_pend_q, wrap_pend_d;

  logic [N-1:0]  mask;
  logic          sel_legal;
  logic          entry;
  logic [SW-1:0] eff_sel, nxt_sel;
  logic [CW-1:0] eff_cnt;

`ifdef MUXSEQ_MASK_EN
  assign mask = ch_mask_i;
`else
  assign mask = '1;
`endif

  function automatic logic [W-1:0] chan(input logic [N*W-1:0] bus, input logic [SW-1:0] idx);
    chan = '0;
    if (int'(idx) < N) chan = bus[int'(idx)*W +: W];
  endfunction

  function automatic logic [SW-1:0] first_chan(input logic [N-1:0] m);
    first_chan = '0;
    for (int k = N - 1; k >= 0; k--)
      if (m[k]) first_chan = SW'(k);
  endfunction

  // Closest enabled channel circularly above cur; distance N lands on cur itself.
  function automatic logic [SW-1:0] next_chan(input logic [SW-1:0] cur, input logic [N-1:0] m);
    int idx;
    next_chan = cur;
    for (int k = N; k >= 1; k--) begin
      idx = int'(cur) + k;
      if (idx >= N) idx = idx - N;
      if (m[idx]) next_chan = SW'(idx);
    end
  endfunction

  always_comb begin
    state_d = IDLE;
    if (en_i) state_d = mode_i ? SCAN : MANUAL;
  end

  assign sel_legal = (int'(sel_i) < N) && mask[int'(sel_i) % N];

  always_comb begin
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    wrap_d      = 1'b0;
    cur_sel_d   = '0;
    dwell_d     = '0;
    wrap_pend_d = 1'b0;
    entry       = 1'b0;
    eff_sel     = '0;
    eff_cnt     = '0;
    nxt_sel     = '0;
    case (state_d)
      MANUAL: begin
        if (sel_legal) begin
          out_d     = chan(in_i, sel_i);
          out_sel_d = sel_i;
          valid_d   = 1'b1;
        end else begin
          out_d = '0;
          err_d = 1'b1;
        end
      end
      SCAN: begin
        entry   = (state_q != SCAN);
        eff_sel = entry ? first_chan(mask) : cur_sel_q;
        eff_cnt = entry ? '0 : dwell_q;
        if (mask == '0) begin
          cur_sel_d = eff_sel;
          dwell_d   = eff_cnt;
        end else begin
          out_d     = chan(in_i, eff_sel);
          out_sel_d = eff_sel;
          valid_d   = 1'b1;
          wrap_d    = wrap_pend_q;
          if (eff_cnt == DWELL_LAST) begin
            nxt_sel     = next_chan(eff_sel, mask);
            cur_sel_d   = nxt_sel;
            wrap_pend_d = (nxt_sel <= eff_sel);
          end else begin
            cur_sel_d = eff_sel;
            dwell_d   = eff_cnt + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_sel_q   <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
      cur_sel_q   <= '0;
      dwell_q     <= '0;
      wrap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
      cur_sel_q   <= cur_sel_d;
      dwell_q     <= dwell_d;
      wrap_pend_q <= wrap_pend_d;
    end
  end

  assign out_o       = out_q;
  assign out_sel_o   = out_sel_q;
  assign out_valid_o = valid_q;
  assign sel_err_o   = err_q;
  assign scan_wrap_o = wrap_q;

endmodule

// File: tb/tb_mux_nto1_seq.sv
// Directed bench for mux_nto1_seq: N=6, W=4, DWELL=3, channel k carries k+3.
module tb_mux_nto1_seq;
  localparam int N = 6;
  localparam int W = 4;
  localparam int DWELL = 3;
  localparam int SW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_v;
  logic [SW-1:0]  sel;
  logic           en;
  logic           mode;
  logic [W-1:0]   out;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           sel_err;
  logic           scan_wrap;
`ifdef MUXSEQ_MASK_EN
  logic [N-1:0]   ch_mask = '1;
`endif

  int total = 0;
  int bad = 0;

  mux_nto1_seq #(.N(N), .W(W), .DWELL(DWELL)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .in_i(in_v),
    .sel_i(sel),
    .en_i(en),
    .mode_i(mode),
`ifdef MUXSEQ_MASK_EN
    .ch_mask_i(ch_mask),
`endif
    .out_o(out),
    .out_sel_o(out_sel),
    .out_valid_o(out_valid),
    .sel_err_o(sel_err),
    .scan_wrap_o(scan_wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] o, input logic [31:0] s,
                         input logic [31:0] v, input logic [31:0] e, input logic [31:0] w);
    chk({tag, ".out"}, 32'(out), o);
    chk({tag, ".out_sel"}, 32'(out_sel), s);
    chk({tag, ".out_valid"}, 32'(out_valid), v);
    chk({tag, ".sel_err"}, 32'(sel_err), e);
    chk({tag, ".scan_wrap"}, 32'(scan_wrap), w);
  endtask

  initial begin
    logic [W-1:0] exp_out;
    int exp_sel;
    in_v  = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3};
    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 1'b0;
    sel   = 3'd4;
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0, 0);

    rst_n = 1'b1;
    sel = 3'd5;
    tick();
    chk_all("man_sel5", 8, 5, 1, 0, 0);
    sel = 3'd2;
    tick();
    chk_all("man_sel2", 5, 2, 1, 0, 0);
    sel = 3'd7;
    tick();
    chk_all("man_illegal", 0, 2, 0, 1, 0);
    sel = 3'd1;
    tick();
    chk_all("man_recover", 4, 1, 1, 0, 0);

    en = 1'b0;
    tick();
    chk_all("idle_hold", 4, 1, 0, 0, 0);

    // Full scan: each channel held DWELL cycles, wrap flagged on return to 0.
    en = 1'b1;
    mode = 1'b1;
    for (int i = 0; i <= N*DWELL + 1; i++) begin
      if (i == 1) in_v[W-1:0] = 4'hA;
      if (i == 2) in_v[W-1:0] = 4'd3;
      tick();
      exp_sel = (i / DWELL) % N;
      exp_out = in_v[exp_sel*W +: W];
      chk($sformatf("scan[%0d]", i), 32'(out), 32'(exp_out));
      chk($sformatf("scan_sel[%0d]", i), 32'(out_sel), 32'(exp_sel));
      chk($sformatf("scan_vld[%0d]", i), 32'(out_valid), 1);
      chk($sformatf("scan_wrap[%0d]", i), 32'(scan_wrap), (i == N*DWELL) ? 1 : 0);
    end

    en = 1'b0;
    tick();
    chk("idle2.out_valid", 32'(out_valid), 0);
    en = 1'b1;
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("intr_sel[%0d]", i), 32'(out_sel), (i < 3) ? 0 : 1);
    end
    mode = 1'b0;
    sel = 3'd3;
    tick();
    chk_all("intr_man1", 6, 3, 1, 0, 0);
    tick();
    chk_all("intr_man2", 6, 3, 1, 0, 0);
    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("reentry_sel[%0d]", i), 32'(out_sel), (i < 3) ? 0 : 1);
      chk($sformatf("reentry_out[%0d]", i), 32'(out), (i < 3) ? 3 : 4);
      chk($sformatf("reentry_wrap[%0d]", i), 32'(scan_wrap), 0);
    end

    rst_n = 1'b0;
    tick();
    chk_all("reset_mid", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst_sel[%0d]", i), 32'(out_sel), (i < 3) ? 0 : 1);
      chk($sformatf("post_rst_vld[%0d]", i), 32'(out_valid), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
